// File: rtl/spi_pwm_pkg.sv
// Shared register map, bit positions and FSM encoding for the SPI-configured PWM timer.
// Latency: n/a (declarations only); backpressure: n/a.
package spi_pwm_pkg;
    localparam int REG_CTRL     = 0;
    localparam int REG_PER_LO   = 1;
    localparam int REG_PER_HI   = 2;
    localparam int REG_DUTY_LO  = 3;
    localparam int REG_DUTY_HI  = 4;
    localparam int REG_PRESCALE = 5;
    localparam int REG_IRQMASK  = 6;
    localparam int REG_RSVD     = 7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_CLR     = 2;

    localparam int ST_RUNNING   = 0;
    localparam int ST_WRAP      = 1;
    localparam int ST_DONE      = 2;
    localparam int ST_CFG_ERR   = 3;
    localparam int ST_WCNT_LSB  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pwm_state_t;
endpackage

// File: rtl/spi_pwm_timer_if.sv
// Register-bank side bundle: flat config vector in, status byte / PWM pin / interrupt out.
// Latency: n/a (wires only); backpressure: none, config is a level-sampled vector.
interface spi_pwm_timer_if #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8
);
    logic [NUM_REGS*WIDTH-1:0] config_regs;
    logic [WIDTH-1:0]          status_regs;
    logic                      pwm_out;
    logic                      irq;

    modport master (
        output config_regs,
        input  status_regs,
        input  pwm_out,
        input  irq
    );

    modport slave (
        input  config_regs,
        output status_regs,
        output pwm_out,
        output irq
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..prescale while run is high, tick on the terminal count.
// Latency: tick is combinational from the counter; backpressure: none, ena=0 freezes the count.
module pwm_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             run,
    input  logic [WIDTH-1:0] prescale,
    output logic             tick
);
    logic [WIDTH-1:0] r_presc;

    assign tick = run && (r_presc == prescale);

    // Held at zero outside RUN so every RUN entry starts a fresh prescale interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (ena) begin
            if (!run || tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_pwm_timer.sv
// Prescaled 16-bit PWM/timer with double-buffered period/duty, sticky status and maskable irq.
// Latency: outputs registered, one clock behind internal state; backpressure: none, ena=0 freezes all state.
module spi_pwm_timer
    import spi_pwm_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 2 * WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    spi_pwm_timer_if.slave bus
);
    logic [WIDTH-1:0] w_ctrl;
    logic [WIDTH-1:0] w_prescale;
    logic [WIDTH-1:0] w_mask;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_duty;
    logic [WIDTH-1:0] w_status;
    logic             w_en;
    logic             w_oneshot;
    logic             w_clr_rise;
    logic             w_tick;
    logic             w_cfg_err;
    logic             w_enter;
    logic             w_wrap;
    logic             w_wrap_set;
    logic             w_done_set;
    logic             w_irq_nxt;
    logic             w_unused;
    pwm_state_t       w_state_nxt;

    pwm_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic [3:0]       r_wrap_cnt;
    logic             r_wrap;
    logic             r_done;
    logic             r_clr_d;
    logic             r_pwm;
    logic             r_irq;
    logic [WIDTH-1:0] r_status;

    assign w_ctrl     = bus.config_regs[REG_CTRL*WIDTH +: WIDTH];
    assign w_period   = {bus.config_regs[REG_PER_HI*WIDTH +: WIDTH], bus.config_regs[REG_PER_LO*WIDTH +: WIDTH]};
    assign w_duty     = {bus.config_regs[REG_DUTY_HI*WIDTH +: WIDTH], bus.config_regs[REG_DUTY_LO*WIDTH +: WIDTH]};
    assign w_prescale = bus.config_regs[REG_PRESCALE*WIDTH +: WIDTH];
    assign w_mask     = bus.config_regs[REG_IRQMASK*WIDTH +: WIDTH];
    assign w_unused   = ^{bus.config_regs[NUM_REGS*WIDTH-1:REG_RSVD*WIDTH], w_ctrl[WIDTH-1:3], w_mask[WIDTH-1:3]};

    assign w_en       = w_ctrl[CTRL_EN];
    assign w_oneshot  = w_ctrl[CTRL_ONESHOT];
    assign w_clr_rise = w_ctrl[CTRL_CLR] & ~r_clr_d;
    assign w_cfg_err  = (r_duty_sh > r_period_sh);

    pwm_prescaler #(
        .WIDTH(WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .run      (r_state == RUN),
        .prescale (w_prescale),
        .tick     (w_tick)
    );

    // EN low wins over any counter event in RUN, so a wrap is only seen while staying enabled.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) begin
                    w_state_nxt = RUN;
                    w_enter     = 1'b1;
                end
            end
            RUN: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                end else if (w_tick && (r_cnt == r_period_sh)) begin
                    w_wrap = 1'b1;
                    if (w_oneshot) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!w_en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The terminal wrap of a one-shot reports DONE instead of WRAP but still counts.
    assign w_done_set = w_wrap & w_oneshot;
    assign w_wrap_set = w_wrap & ~w_oneshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
        end else if (ena) begin
            if (w_enter || w_wrap) begin
                r_cnt       <= '0;
                r_period_sh <= w_period;
                r_duty_sh   <= w_duty;
            end else if ((r_state == RUN) && w_en && w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Set beats clear when both land on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap_cnt <= '0;
            r_clr_d    <= 1'b0;
        end else if (ena) begin
            r_clr_d <= w_ctrl[CTRL_CLR];
            if (w_wrap_set) begin
                r_wrap <= 1'b1;
            end else if (w_clr_rise) begin
                r_wrap <= 1'b0;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_clr_rise) begin
                r_done <= 1'b0;
            end
            if (w_wrap) begin
                r_wrap_cnt <= w_clr_rise ? 4'd1 : r_wrap_cnt + 4'd1;
            end else if (w_clr_rise) begin
                r_wrap_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[ST_RUNNING]           = (r_state == RUN);
        w_status[ST_WRAP]              = r_wrap;
        w_status[ST_DONE]              = r_done;
        w_status[ST_CFG_ERR]           = w_cfg_err;
        w_status[ST_WCNT_LSB +: 4]     = r_wrap_cnt;
        w_irq_nxt                      = |({w_cfg_err, r_done, r_wrap} & w_mask[2:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm    <= 1'b0;
            r_irq    <= 1'b0;
            r_status <= '0;
        end else if (ena) begin
            r_pwm    <= (r_state == RUN) && (r_cnt < r_duty_sh);
            r_irq    <= w_irq_nxt;
            r_status <= w_status;
        end
    end

    assign bus.status_regs = r_status;
    assign bus.pwm_out     = r_pwm;
    assign bus.irq         = r_irq;
endmodule
